product_display: RTL and testbench

- Output stage directly downstream of the Booth multiplier controller and datapath.
- When the controller asserts its done indication, the block captures the 16-bit signed product and converts its magnitude to 5 BCD digits using sequential double-dabble, one bit per cycle.
- It then drives a time-multiplexed 6-digit, active-low 7-segment display: digit 5 is the sign, digits 4..0 are the magnitude.

---
 rtl/product_display_pkg.sv | 36 +++
 rtl/product_display_if.sv | 16 +
 rtl/product_display_seg7_decode.sv | 18 +
 rtl/product_display.sv | 162 ++++++++++++++++
 tb/tb_product_display.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/product_display_pkg.sv
// Shared definitions for the product display: FSM encoding, segment codes,
// digit table and the double-dabble nibble adjust helper.
package product_display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BCD_DIGITS = NUM_DIGITS - 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_SHOW    = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the least significant slot.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic             on;
    logic             sign;
    logic [BCD_W-1:0] bcd;
  } disp_t;

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      r[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/product_display_if.sv
// Handshake and display bus between the multiplier controller, this output
// stage and the 7-segment pins.
interface product_display_if #(
  parameter int DATA_W = 16
);
  logic              over;
  logic              clr;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              valid;
  logic [5:0]        an;
  logic [6:0]        seg;

  modport master (output over, clr, result, input busy, valid, an, seg);
  modport slave  (input over, clr, result, output busy, valid, an, seg);
endinterface

// File: rtl/product_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment code; blank or non-decimal
// input turns every segment off.
module seg7_decode
  import product_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && bcd_i <= 4'd9) begin
      seg_o = SEG_TABLE[bcd_i];
    end
  end

endmodule

// File: rtl/product_display.sv
// Captures a signed product, converts its magnitude to BCD by double-dabble and
// scans it onto a 6-digit display. Option: LEADING_ZERO_BLANK_EN.
module product_display
  import product_display_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  product_display_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]        state_q, state_d;
  logic              over_q;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sign_q, sign_d;
  disp_t             disp_q, disp_d;
  logic [DIV_W-1:0]  div_q;
  logic [2:0]        idx_q;
  logic [5:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic                    rise;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+DATA_W-1:0] shifted;

  assign rise    = bus.over & ~over_q;
  assign bcd_adj = bcd_adjust(bcd_q);
  assign shifted = {bcd_adj, bin_q} << 1;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    disp_d  = disp_q;
    if (bus.clr) begin
      state_d   = ST_IDLE;
      disp_d.on = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_SHOW: begin
          if (rise) begin
            bin_d   = bus.result[DATA_W-1] ? (~bus.result + 1'b1) : bus.result;
            sign_d  = bus.result[DATA_W-1];
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          {bcd_d, bin_d} = shifted;
          cnt_d          = cnt_q + 4'd1;
          // The display only ever sees a finished conversion.
          if (cnt_q == 4'd15) begin
            disp_d.bcd  = shifted[BCD_W+DATA_W-1:DATA_W];
            disp_d.sign = sign_q;
            disp_d.on   = 1'b1;
            state_d     = ST_SHOW;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Digits above the most significant nonzero one are marked as leading zeros.
  logic [BCD_DIGITS-1:0] lz;
  logic [3:0]            nib [BCD_DIGITS];
  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_nib
      assign nib[gi] = disp_q.bcd[4*gi +: 4];
    end
`ifdef LEADING_ZERO_BLANK_EN
    assign lz[0] = 1'b0;
    for (gi = 1; gi < BCD_DIGITS; gi++) begin : g_lz
      assign lz[gi] = (disp_q.bcd[BCD_W-1:4*gi] == '0);
    end
`else
    assign lz = '0;
`endif
  endgenerate

  logic [3:0] mux_bcd;
  logic       mux_blank;
  logic [6:0] dec_seg;

  always_comb begin
    mux_bcd   = '0;
    mux_blank = 1'b1;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (idx_q == 3'(k)) begin
        mux_bcd   = nib[k];
        mux_blank = ~disp_q.on | lz[k];
      end
    end
  end

  seg7_decode u_seg7_decode (
    .bcd_i   (mux_bcd),
    .blank_i (mux_blank),
    .seg_o   (dec_seg)
  );

  always_comb begin
    an_d  = 6'h3F;
    seg_d = SEG_BLANK;
    if (state_q != ST_IDLE) begin
      an_d = ~(6'b000001 << idx_q);
      if (idx_q == 3'(NUM_DIGITS - 1)) begin
        seg_d = (disp_q.on && disp_q.sign) ? SEG_MINUS : SEG_BLANK;
      end else begin
        seg_d = dec_seg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      over_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      disp_q  <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= 6'h3F;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      over_q  <= bus.over;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      disp_q  <= disp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        div_q <= '0;
        idx_q <= (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign bus.busy  = (state_q == ST_CONVERT);
  assign bus.valid = (state_q == ST_SHOW);
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;

endmodule

// File: tb/tb_product_display.sv
// Self-checking bench for product_display: directed cases plus random over/clr
// traffic against an arithmetic reference model (honours LEADING_ZERO_BLANK_EN).
module tb_product_display;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  product_display_if #(.DATA_W(16)) bus ();

  product_display #(.DATA_W(16), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: abstract state, remaining conversion cycles, integer magnitudes.
  logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int  m_state;   // 0 idle, 1 converting, 2 showing
  int  m_left;
  int  m_val;
  bit  m_sign;
  int  d_val;
  bit  d_sign;
  bit  d_on;
  bit  m_over_q;
  int  m_cyc;
  logic [5:0] e_an;
  logic [6:0] e_seg;

  function automatic logic [6:0] digit_seg(input int k);
    int pow;
    if (!d_on) return 7'h7F;
    if (k == 5) return d_sign ? 7'h3F : 7'h7F;
    pow = 1;
    for (int j = 0; j < k; j++) pow = pow * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && d_val < pow) return 7'h7F;
`endif
    return codes[(d_val / pow) % 10];
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_left   = 0;
    d_on     = 1'b0;
    d_val    = 0;
    d_sign   = 1'b0;
    m_over_q = 1'b0;
    m_cyc    = 0;
  endtask

  task automatic step();
    int  idx;
    bit  rise;
    int  r;
    idx   = (m_cyc / SCAN_DIV) % 6;
    e_an  = (m_state == 0) ? 6'h3F : ~(6'b000001 << idx);
    e_seg = (m_state == 0) ? 7'h7F : digit_seg(idx);
    rise     = bus.over && !m_over_q;
    m_over_q = bus.over;
    m_cyc++;
    if (bus.clr) begin
      m_state = 0;
      d_on    = 1'b0;
    end else if (m_state != 1 && rise) begin
      r       = int'($signed(bus.result));
      m_val   = (r < 0) ? -r : r;
      m_sign  = (r < 0);
      m_left  = 16;
      m_state = 1;
    end else if (m_state == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_state = 2;
        d_val   = m_val;
        d_sign  = m_sign;
        d_on    = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("busy",  32'(bus.busy),  32'(m_state == 1));
    check("valid", 32'(bus.valid), 32'(m_state == 2));
    check("an",    32'(bus.an),    32'(e_an));
    check("seg",   32'(bus.seg),   32'(e_seg));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic hard_reset();
    rst = 1'b0;
    #1;
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_an",    32'(bus.an),    32'h3F);
    check("rst_seg",   32'(bus.seg),   32'h7F);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic convert(input logic [15:0] r);
    bus.result = r;
    bus.over   = 1'b1;
    step();
    bus.over   = 1'b0;
    bus.result = 16'($urandom);
    run(16 + 28);
  endtask

  initial begin
    bus.over   = 1'b0;
    bus.clr    = 1'b0;
    bus.result = '0;
    model_reset();
    @(negedge clk);
    hard_reset();
    run(30);

    convert(16'h3039);
    convert(16'hFF85);
    convert(16'h8000);
    convert(16'h0000);

    // second rise while converting must be ignored
    bus.result = 16'd100;
    bus.over   = 1'b1;
    step();
    bus.over = 1'b0;
    run(5);
    bus.result = 16'd999;
    bus.over   = 1'b1;
    step();
    bus.over = 1'b0;
    run(40);

    // clr coincident with rise wins
    bus.over = 1'b1;
    bus.clr  = 1'b1;
    step();
    bus.clr  = 1'b0;
    bus.over = 1'b0;
    run(12);

    // reset in the middle of a conversion
    bus.result = 16'h3039;
    bus.over   = 1'b1;
    step();
    bus.over = 1'b0;
    run(7);
    hard_reset();
    run(3);
    convert(16'hFF85);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.result = 16'($urandom);
      if ($urandom_range(0, 19) == 0) bus.over = ~bus.over;
      bus.clr = ($urandom_range(0, 99) == 0);
      step();
    end
    bus.clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
